// File: rtl/srt4_pkg.sv
// Shared definitions for the SRT-4 on-the-fly quotient converter.
// Holds the signed-digit codes produced by the SRT-4 quotient selection
// table, the datapath sizes and the converter FSM state type.
package srt4_pkg;

    localparam int NDIGITS = 4;
    localparam int QW      = 8;
    localparam int CW      = $clog2(NDIGITS);

    // Signed-digit codes: bit 2 is the sign, bits 1:0 the magnitude.
    localparam logic [2:0] D0  = 3'b000;
    localparam logic [2:0] DP1 = 3'b001;
    localparam logic [2:0] DP2 = 3'b010;
    localparam logic [2:0] DN1 = 3'b101;
    localparam logic [2:0] DN2 = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/srt4_quotient_converter_if.sv
// Handshake bundle between a divider core (master) and the quotient
// converter (slave).
//   start        : begin a conversion (honoured only when idle)
//   digit_valid  : digit holds a quotient digit
//   digit        : signed-digit code
//   digit_ready  : converter accepts digits (ACCUM only)
//   sign_valid   : neg_rem holds the final remainder sign
//   neg_rem      : final remainder negative, quotient must be decremented
//   quotient     : corrected quotient
//   busy/done/err: status; state is a debug view of the FSM
//
// Handshake rule: a digit transfers on a rising edge where
// digit_valid && digit_ready; the sign transfers on a rising edge where
// sign_valid is high while the converter is in FINAL. Inputs seen at any
// other time are ignored, and a low valid simply stalls the converter.
interface srt4_quotient_converter_if;
    import srt4_pkg::*;

    logic          start;
    logic          digit_valid;
    logic [2:0]    digit;
    logic          digit_ready;
    logic          sign_valid;
    logic          neg_rem;
    logic [QW-1:0] quotient;
    logic          busy;
    logic          done;
    logic          err;
    state_t        state;

    modport master (
        output start, digit_valid, digit, sign_valid, neg_rem,
        input  digit_ready, quotient, busy, done, err, state
    );

    modport slave (
        input  start, digit_valid, digit, sign_valid, neg_rem,
        output digit_ready, quotient, busy, done, err, state
    );

endinterface

// File: rtl/srt4_otf_step.sv
// One on-the-fly conversion step. Given the current pair Q / QM (QM = Q-1)
// and a signed quotient digit, produces the pair after appending the digit.
// Ports:
//   q, qm    : current conversion registers
//   digit    : signed-digit code
//   q_next   : Q after the digit
//   qm_next  : QM after the digit
//   illegal  : digit code is not one of the five legal codes
module srt4_otf_step
    import srt4_pkg::*;
(
    input  logic [QW-1:0] q,
    input  logic [QW-1:0] qm,
    input  logic [2:0]    digit,
    output logic [QW-1:0] q_next,
    output logic [QW-1:0] qm_next,
    output logic          illegal
);

    // Negative digits borrow from QM so no carry chain is ever needed;
    // an illegal code is appended as digit 0.
    always_comb begin
        q_next  = {q[QW-3:0], 2'b00};
        qm_next = {qm[QW-3:0], 2'b11};
        illegal = 1'b0;
        case (digit)
            D0: ;
            DP1: begin
                q_next  = {q[QW-3:0], 2'b01};
                qm_next = {q[QW-3:0], 2'b00};
            end
            DP2: begin
                q_next  = {q[QW-3:0], 2'b10};
                qm_next = {q[QW-3:0], 2'b01};
            end
            DN1: begin
                q_next  = {qm[QW-3:0], 2'b11};
                qm_next = {qm[QW-3:0], 2'b10};
            end
            DN2: begin
                q_next  = {qm[QW-3:0], 2'b10};
                qm_next = {qm[QW-3:0], 2'b01};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/srt4_quotient_converter.sv
// SRT-4 quotient converter: accumulates four radix-4 signed digits into a
// binary quotient with on-the-fly conversion, then applies the final
// remainder-sign correction by choosing QM (= Q-1) when the remainder is
// negative.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of srt4_quotient_converter_if
module srt4_quotient_converter
    import srt4_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    srt4_quotient_converter_if.slave      bus
);

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [QW-1:0] q, qm, quotient_r;
    logic [QW-1:0] q_step, qm_step;
    logic          step_illegal;
    logic          err_r;

    logic start_acc, digit_acc, sign_acc, last_digit;

    assign start_acc  = bus.start       && (state == S_IDLE);
    assign digit_acc  = bus.digit_valid && (state == S_ACCUM);
    assign sign_acc   = bus.sign_valid  && (state == S_FINAL);
    assign last_digit = (count == CW'(NDIGITS - 1));

    srt4_otf_step u_step (
        .q       (q),
        .qm      (qm),
        .digit   (bus.digit),
        .q_next  (q_step),
        .qm_next (qm_step),
        .illegal (step_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_acc)               state_next = S_ACCUM;
            S_ACCUM: if (digit_acc && last_digit) state_next = S_FINAL;
            S_FINAL: if (sign_acc)                state_next = S_DONE;
            S_DONE:                               state_next = S_IDLE;
            default:                              state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            qm         <= '1;
            count      <= '0;
            err_r      <= 1'b0;
            quotient_r <= '0;
        end else begin
            if (start_acc) begin
                q     <= '0;
                qm    <= '1;
                count <= '0;
                err_r <= 1'b0;
            end
            if (digit_acc) begin
                q     <= q_step;
                qm    <= qm_step;
                count <= count + CW'(1);
                if (step_illegal) err_r <= 1'b1;
            end
            if (sign_acc) quotient_r <= bus.neg_rem ? qm : q;
        end
    end

    // Every output is a register or a decode of the state register.
    assign bus.digit_ready = (state == S_ACCUM);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.err         = err_r;
    assign bus.quotient    = quotient_r;
    assign bus.state       = state;

endmodule

// File: tb/tb_srt4_quotient_converter.sv
// Self-checking bench for srt4_quotient_converter: directed vector table,
// hand-written reset / start-hold sequences and randomized conversions
// checked against an arithmetic model of the radix-4 quotient.
module tb_srt4_quotient_converter;
    import srt4_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    srt4_quotient_converter_if bus ();

    srt4_quotient_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    // ---------------- reference model ----------------
    function automatic int digit_val(input logic [2:0] code);
        case (code)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b010:  return 2;
            3'b101:  return -1;
            3'b110:  return -2;
            default: return 0;
        endcase
    endfunction

    function automatic bit digit_bad(input logic [2:0] code);
        return !(code == 3'b000 || code == 3'b001 || code == 3'b010 ||
                 code == 3'b101 || code == 3'b110);
    endfunction

    // Quotient = sum of d_i * 4^(3-i), minus one when the remainder is negative.
    function automatic logic [7:0] model_q(input logic [11:0] digs, input logic neg);
        int acc = 0;
        for (int i = 0; i < 4; i++) acc = acc * 4 + digit_val(digs[11-3*i -: 3]);
        acc = acc - int'(neg);
        return 8'(acc);
    endfunction

    function automatic logic model_err(input logic [11:0] digs);
        logic e = 1'b0;
        for (int i = 0; i < 4; i++) e = e | digit_bad(digs[11-3*i -: 3]);
        return e;
    endfunction

    // ---------------- checking / driving ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_conv(input logic [11:0] digs, input logic neg, input logic [7:0] exp_qv,
                            input logic exp_e, input int stall_max, input bit hold_start);
        int cyc;
        int done0;
        int st;
        done0 = done_cnt;
        bus.start = 1'b1;
        cyc = 1;
        step(); cyc++;
        if (!hold_start) bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("err_cleared_by_start", bus.err, 0);
        for (int i = 0; i < 4; i++) begin
            st = $urandom_range(0, stall_max);
            repeat (st) begin
                bus.digit_valid = 1'b0;
                bus.digit = 3'($urandom);
                step(); cyc++;
            end
            if (bus.digit_ready !== 1'b1) check("digit_ready_in_accum", bus.digit_ready, 1);
            bus.digit_valid = 1'b1;
            bus.digit = digs[11-3*i -: 3];
            step(); cyc++;
        end
        bus.digit_valid = 1'b0;
        check("ready_low_in_final", bus.digit_ready, 0);
        st = $urandom_range(0, stall_max);
        repeat (st) begin
            bus.sign_valid = 1'b0;
            bus.neg_rem = 1'($urandom);
            step(); cyc++;
        end
        bus.sign_valid = 1'b1;
        bus.neg_rem = neg;
        exp_q.push_back(exp_qv);
        step(); cyc++;
        bus.sign_valid = 1'b0;
        check("done_pulse", bus.done, 1);
        check("quotient", bus.quotient, exp_q[0]);
        check("err", bus.err, exp_e);
        if (stall_max == 0) check("latency_cycles", cyc, 7);
        step();
        bus.start = 1'b0;
        check("idle_after_done", bus.busy, 0);
        check("done_once", done_cnt - done0, 1);
        check("quotient_held", bus.quotient, exp_q.pop_front());
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [11:0] digs;
        logic        neg;
        logic [7:0]  q;
        logic        e;
        int          stall_max;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [11:0] rd;
        logic        rn;
        logic [2:0]  legal [5];
        int          done0;

        legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
        legal[3] = 3'b101; legal[4] = 3'b110;

        // +1,+2,-1,0 = 64+32-4 = 92
        vecs[0] = '{12'b001_010_101_000, 1'b0, 8'h5C, 1'b0, 0};
        vecs[1] = '{12'b001_010_101_000, 1'b1, 8'h5B, 1'b0, 0};
        vecs[2] = '{12'b010_010_010_010, 1'b0, 8'hAA, 1'b0, 0};
        vecs[3] = '{12'b000_000_000_000, 1'b1, 8'hFF, 1'b0, 0};
        // +1, illegal(as 0), +1, +1 = 64+4+1 = 69
        vecs[4] = '{12'b001_011_001_001, 1'b0, 8'h45, 1'b1, 0};
        // -2,+1,0,+2 = -128+16+2 = -110 = 0x92 (mod 256), with stalls
        vecs[5] = '{12'b110_001_000_010, 1'b0, 8'h92, 1'b0, 5};

        // Reset held with every input active: reset must win.
        bus.start = 1'b1; bus.digit_valid = 1'b1; bus.digit = 3'b001;
        bus.sign_valid = 1'b1; bus.neg_rem = 1'b1;
        rst = 1'b1;
        step(); step();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_ready", bus.digit_ready, 0);
        check("rst_quotient", bus.quotient, 0);
        bus.start = 1'b0;
        rst = 1'b0;
        // Digits and sign offered while idle are ignored.
        step(); step();
        check("idle_ignores_digits", bus.busy, 0);
        check("idle_no_done", done_cnt, 0);
        bus.digit_valid = 1'b0; bus.sign_valid = 1'b0;
        step();

        for (int i = 0; i < 6; i++)
            run_conv(vecs[i].digs, vecs[i].neg, vecs[i].q, vecs[i].e, vecs[i].stall_max, 1'b0);

        // start held through ACCUM, FINAL and DONE: no restart, no extra done.
        run_conv(12'b001_001_001_001, 1'b0, 8'h55, 1'b0, 0, 1'b1);
        step();
        check("no_restart_after_held_start", bus.busy, 0);

        // Reset mid-conversion abandons it.
        done0 = done_cnt;
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.digit_valid = 1'b1; bus.digit = 3'b010; step(); step();
        bus.digit_valid = 1'b0;
        rst = 1'b1; step(); step(); rst = 1'b0;
        check("abandon_busy", bus.busy, 0);
        check("abandon_quotient", bus.quotient, 0);
        repeat (6) step();
        check("abandon_no_done", done_cnt - done0, 0);
        run_conv(12'b000_000_000_001, 1'b0, 8'h01, 1'b0, 0, 1'b0);

        // Randomized conversions against the model.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) rd[11-3*i -: 3] = 3'($urandom);
                else rd[11-3*i -: 3] = legal[$urandom_range(0, 4)];
            end
            rn = 1'($urandom);
            run_conv(rd, rn, model_q(rd, rn), model_err(rd), $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
